// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memcontrol-to-bus adapter.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    localparam logic [3:0] WORD_SEL_ALL       = 4'hF;
    localparam int         DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: bus-wait counter that flags the cycle whose missing ack ends the wait.
module bus_timeout_ctr
    import mem_bus_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    // this edge would bring the count to LIMIT
    assign expire = enable && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: turns memcontrol level requests into one Wishbone-classic transfer at a time.
// Defining BUS_TIMEOUT_EN aborts a bus wait after TIMEOUT_CYCLES cycles with an err pulse.
module mem_bus_adapter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_out,
    input  logic [DATA_W-1:0] data_out_BUS,
    input  logic [3:0]        byte_en,
    input  logic              read_req,
    input  logic              write_req,
    output logic [DATA_W-1:0] data_in_BUS,
    output logic              bus_full,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [3:0]        sel_o,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i
);
    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_bus_adapter: DATA_W must be 32 and TIMEOUT_CYCLES at least 1");
    end

    bus_state_t        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d, rdata_q, rdata_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d, abort_q, abort_d;
    logic              timeout;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^address_out[1:0];

`ifdef BUS_TIMEOUT_EN
    bus_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != BUS),
        .enable (state_q == BUS && !ack_i),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: if (write_req || read_req) begin
                state_d = BUS;
                adr_d   = {address_out[ADDR_W-1:2], 2'b00};
                dat_d   = data_out_BUS;
                we_d    = write_req;
                sel_d   = write_req ? byte_en : WORD_SEL_ALL;
                abort_d = 1'b0;
            end
            // ack beats a timeout landing on the same edge
            BUS: if (ack_i) begin
                state_d = DONE;
                rdata_d = we_q ? rdata_q : dat_i;
            end else if (timeout) begin
                state_d = DONE;
                abort_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end

    assign cyc_o       = state_q == BUS;
    assign stb_o       = state_q == BUS;
    assign bus_full    = state_q != IDLE;
    assign done        = state_q == DONE && !abort_q;
    assign err         = state_q == DONE && abort_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign sel_o       = sel_q;
    assign we_o        = we_q;
    assign data_in_BUS = rdata_q;
endmodule

// File: doc/mem_bus_adapter.md
Name: mem_bus_adapter

Overview:
- Sits directly downstream of memcontrol, between it and the shared memory bus (Wishbone-classic style, single outstanding transfer).
- Converts memcontrol's level-held read/write requests into a cyc/stb/ack bus handshake.
- Returns read data to memcontrol on data_in_BUS and back-pressures it with bus_full.
- Latches the whole request so memcontrol inputs may change after acceptance.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width (must be 32; sel is 4 bits)
TIMEOUT_CYCLES, 255, bus-wait cycles before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
address_out  in  ADDR_W  request byte address from memcontrol
data_out_BUS  in  DATA_W  write data from memcontrol
byte_en  in  4  byte lanes for write (reads ignore it, use 4'hF)
read_req  in  1  read request, level, from memcontrol
write_req  in  1  write request, level, from memcontrol
data_in_BUS  out  DATA_W  last completed read data, to memcontrol
bus_full  out  1  adapter busy; memcontrol must hold/ignore
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse (timeout; 0 when feature off)
adr_o  out  ADDR_W  bus address, word-aligned
dat_o  out  DATA_W  bus write data
sel_o  out  4  bus byte select
we_o  out  1  bus write enable
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
dat_i  in  DATA_W  bus read data
ack_i  in  1  bus acknowledge

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including data_in_BUS, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, done and err. Reset mid-transfer drops cyc_o/stb_o immediately; the transfer is lost and no done is issued.
- States: IDLE, BUS, DONE.
- IDLE:
  - On a rising edge with write_req|read_req=1, latch the request:
    - adr_o={address_out[ADDR_W-1:2],2'b00}
    - dat_o=data_out_BUS
    - we_o=write_req
    - sel_o=write_req?byte_en:4'hF
  - Go to BUS.
  - If both requests are high, the write wins; the read is not latched and must be re-presented.
- BUS:
  - cyc_o=stb_o=1 (registered, asserted the cycle after acceptance).
  - adr_o, dat_o, sel_o and we_o are held stable.
  - On ack_i=1 at a rising edge:
    - If reading, data_in_BUS<=dat_i.
    - Drop cyc_o/stb_o and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- bus_full = (state != IDLE), combinational from the state register.
- Requests presented while bus_full=1 are ignored and not queued.
- Latency: request sampled at edge N; cyc_o high N+1; zero-wait ack sampled at edge N+2; done high N+2..N+3. Minimum 3 cycles request-to-next-accept.
- data_in_BUS changes only on a completed read; writes and errors leave it unchanged.
- ack_i outside BUS is ignored (no state change, no done).
- dat_i is sampled only on the ack edge.
- adr_o, dat_o, sel_o and we_o keep their last values in IDLE and DONE; only cyc_o/stb_o qualify them.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUS and increments each BUS cycle without ack_i.
  - When it reaches TIMEOUT_CYCLES with no ack: drop cyc_o/stb_o, pulse err=1 for one cycle (in DONE, with done=0), return to IDLE. data_in_BUS is unchanged.
  - ack_i on the same edge as the timeout wins: normal completion.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; BUS waits indefinitely; err is tied to 0.

Decomposition:
- Package mem_bus_pkg:
  - bus_state_t enum {IDLE=0,BUS=1,DONE=2}, 2 bits
  - WORD_SEL_ALL=4'hF
  - default TIMEOUT_CYCLES constant
- Sub-module bus_timeout_ctr: clear, enable, terminal-count output; instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Reset: rst=0 with read_req=1, ack_i=1 for 2 cycles → all outputs 0, bus_full=0; after release, the held read is accepted on the next edge.
- Read, zero wait: address_out=32'h0000_1006, read_req=1; ack_i=1 with dat_i=32'hDEAD_BEEF the cycle cyc_o rises → adr_o=32'h0000_1004, sel_o=4'hF, we_o=0, data_in_BUS=32'hDEAD_BEEF, done for 1 cycle, bus_full high exactly 2 cycles.
- Write, 3 wait states: address_out=32'h40, data_out_BUS=32'h1234_5678, byte_en=4'b0011, write_req=1, ack_i after 3 cycles → cyc_o/stb_o high 4 cycles, dat_o/sel_o/we_o stable, data_in_BUS unchanged, done pulses once.
- Simultaneous read_req=write_req=1 → we_o=1; a second request during busy is ignored; spurious ack_i in IDLE causes no done.
- Reset mid-transfer: rst=0 two cycles into BUS → cyc_o=0 immediately, no done, state IDLE.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4: no ack_i → cyc_o drops after 4 wait cycles, err=1 one cycle, done=0, data_in_BUS unchanged; repeat with ack_i on the 4th cycle → normal done, err=0.
